fifo_datos_10b: RTL and testbench
=================================

Name: fifo_datos_10b

Overview:
- Synchronous FIFO that buffers 10-bit data words and feeds them one word per pop to the downstream word counter on its data_in port.
- Sits directly upstream of the counter stage.
- Provides full/empty and programmable almost-full/almost-empty flags for the upstream flow-control logic.
- Provides a sticky error flag for overflow and underflow.

Parameters:
- DATA_WIDTH, 10, width of each stored word.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8 words.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- push, input, 1, write request; data_in is captured when accepted.
- data_in, input, DATA_WIDTH, word to store.
- pop, input, 1, read request.
- afull_thr, input, ADDR_WIDTH+1, almost-full threshold in words.
- aempty_thr, input, ADDR_WIDTH+1, almost-empty threshold in words.
- data_out, output, DATA_WIDTH, popped word; connects to the counter's data_in.
- valid_out, output, 1, data_out holds a popped word this cycle.
- full, output, 1, occupancy == DEPTH.
- empty, output, 1, occupancy == 0.
- almost_full, output, 1, occupancy >= afull_thr.
- almost_empty, output, 1, occupancy <= aempty_thr.
- fifo_error, output, 1, sticky overflow/underflow indicator.
- occupancy, output, ADDR_WIDTH+1, current number of stored words (0..DEPTH).

Behaviour:
- Reset (reset = 0, asynchronous):
  - wr_ptr = rd_ptr = occupancy = 0.
  - data_out = 0, valid_out = 0, fifo_error = 0.
  - Flags follow from occupancy = 0: empty = 1, full = 0, almost_full = (0 >= afull_thr), almost_empty = 1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words. No pop is honoured in the cycle reset deasserts unless the FIFO is non-empty, which it cannot be.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH (7 -> 0). Full/empty are decided by the occupancy counter, not by pointer comparison.
- Push accepted when push = 1 and (full = 0 or pop is accepted in the same cycle):
  - mem[wr_ptr] <= data_in; wr_ptr increments.
- Pop accepted when pop = 1 and empty = 0:
  - Next cycle: data_out = mem[rd_ptr] as it was before the edge, valid_out = 1; rd_ptr increments.
  - Latency is exactly 1 cycle from the pop edge.
- Cycles with no accepted pop: valid_out = 0 and data_out = 0. The downstream stage never sees stale data.
- Occupancy update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous events:
  - Full with push+pop: both accepted; occupancy stays at DEPTH; the popped word is the oldest, not the one being written.
  - Empty with push+pop: push accepted; pop is an underflow (no bypass path). occupancy -> 1, valid_out = 0 next cycle, fifo_error set.
  - Non-empty and non-full with push+pop: both accepted.
- Overflow: push = 1 while full and no accepted pop. Word is dropped, pointers unchanged, fifo_error <= 1.
- Underflow: pop = 1 while empty. No pointer change, valid_out = 0, fifo_error <= 1.
- fifo_error stays 1 until reset.
- full, empty, almost_full, almost_empty are combinational compares of the registered occupancy against constants and thresholds. They change the cycle after the causing push/pop.
- Threshold values above DEPTH are legal: afull_thr > 8 means almost_full is never 1; aempty_thr >= 8 means almost_empty is always 1.

Decomposition:
- Shared include file holds DATA_WIDTH and ADDR_WIDTH defaults, with DEPTH derived. The counter stage uses the same file.
- One sub-module: memoria_fifo, a parameterised register-file RAM.
  - One write port: wr_en, wr_addr, wr_data.
  - One read port: combinational rd_addr -> rd_data.
  - No reset on the array.
- fifo_datos_10b holds pointers, occupancy, flags, the output register and the error logic.
- A structural (synthesised) version is produced later with the same ports for equivalence checking in the bench.

Test Plan:
- Reset then idle: reset low 2 cycles, then high -> empty = 1, full = 0, occupancy = 0, valid_out = 0, data_out = 0, fifo_error = 0.
- Fill and drain: push 0x001..0x008 on 8 consecutive cycles -> full = 1, occupancy = 8. Then pop 8 cycles -> data_out = 0x001..0x008 in order, one cycle after each pop; empty = 1 at end.
- Overflow: with FIFO full, push 0x3FF -> occupancy stays 8, fifo_error = 1. The subsequent drain never returns 0x3FF.
- Underflow and empty push+pop: with FIFO empty, assert pop -> valid_out = 0, fifo_error = 1. After reset, push 0x155 and pop together while empty -> occupancy = 1, valid_out = 0, fifo_error = 1.
- Full push+pop and wrap: fill with 0x010..0x017, then push 0x018 with pop -> data_out = 0x010, occupancy = 8. Continue pop-only -> 0x011..0x018, exercising pointer wrap 7 -> 0.
- Thresholds and async reset: afull_thr = 6, aempty_thr = 2. Push 6 words -> almost_full rises after the 6th push and almost_empty falls after the 3rd. Assert reset mid-burst, between clock edges -> outputs return to reset values immediately and occupancy = 0.

Source files
------------

// File: rtl/fifo_datos_10b_pkg.sv
// Shared sizing for the 10-bit data FIFO and the downstream counter stage.
// Holds default word/pointer widths and the derived depth.
package fifo_datos_10b_pkg;

  localparam int unsigned FIFO_DATA_W = 10;
  localparam int unsigned FIFO_ADDR_W = 3;
  localparam int unsigned FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_datos_10b_memoria_fifo.sv
// Register-file RAM: one synchronous write port, one combinational read port.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr -> rd_data (read).
module memoria_fifo
  import fifo_datos_10b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_W,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_W
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  // No reset: contents survive reset, only pointers are cleared.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/fifo_datos_10b.sv
// Synchronous 10-bit data FIFO feeding the word counter; flags + sticky error.
// Ports: clk, reset (async, low), push/data_in, pop, afull_thr/aempty_thr in;
//        data_out/valid_out, full, empty, almost_*, fifo_error, occupancy out.
module fifo_datos_10b
  import fifo_datos_10b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_W,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   afull_thr,
  input  logic [ADDR_WIDTH:0]   aempty_thr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   occupancy
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_occ;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic                  w_ovf;
  logic                  w_unf;

  assign empty = (r_occ == '0);
  assign full  = (r_occ == LP_DEPTH);

  // A pop frees a slot, so a full FIFO still takes a push alongside it.
  // Empty push+pop is not bypassed: the pop is an underflow.
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign w_ovf     = push & full & ~w_pop_ok;
  assign w_unf     = pop & empty;

  memoria_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push_ok),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_occ <= r_occ + 1'b1;
      else if (w_pop_ok && !w_push_ok) r_occ <= r_occ - 1'b1;
      // Zero data on idle cycles so the counter never sees stale words.
      r_valid <= w_pop_ok;
      r_data  <= w_pop_ok ? w_rd_data : '0;
      if (w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign fifo_error   = r_err;
  assign occupancy    = r_occ;
  assign almost_full  = (r_occ >= afull_thr);
  assign almost_empty = (r_occ <= aempty_thr);

endmodule

// File: tb/tb_fifo_datos_10b.sv
// Self-checking bench for fifo_datos_10b: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fifo_datos_10b;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [9:0] data_in = '0;
  logic       pop = 1'b0;
  logic [3:0] afull_thr = 4'd7;
  logic [3:0] aempty_thr = 4'd1;
  logic [9:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;
  logic [3:0] occupancy;

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] q[$];
  logic       m_valid;
  logic [9:0] m_data;
  logic       m_err;

  fifo_datos_10b dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .afull_thr    (afull_thr),
    .aempty_thr   (aempty_thr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_valid = 1'b0;
    m_data = '0;
    m_err = 1'b0;
  endtask

  // Drive one cycle at negedge, advance the model at the edge, settle #1.
  task automatic cyc(input logic pu, input logic po, input logic [9:0] d);
    bit pop_ok;
    bit push_ok;
    int sz;
    @(negedge clk);
    push = pu;
    pop = po;
    data_in = d;
    @(posedge clk);
    sz = q.size();
    pop_ok = po && (sz > 0);
    push_ok = pu && ((sz < 8) || pop_ok);
    if ((pu && sz >= 8 && !pop_ok) || (po && sz == 0)) m_err = 1'b1;
    if (pop_ok) begin
      m_valid = 1'b1;
      m_data = q.pop_front();
    end else begin
      m_valid = 1'b0;
      m_data = '0;
    end
    if (push_ok) q.push_back(d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({empty, full, occupancy, valid_out, data_out, fifo_error}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 10'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got e=%b f=%b o=%0d v=%b d=%h err=%b",
               empty, full, occupancy, valid_out, data_out, fifo_error);
    end
    cyc(1'b0, 1'b0, '0);
    n_checks++;
    if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got ae=%b af=%b want ae=1 af=0",
               almost_empty, almost_full);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 10'(i));
    n_checks++;
    if (full !== 1'b1 || occupancy !== 4'd8) begin
      n_fail++;
      $display("FAIL fill_full got f=%b o=%0d want f=1 o=8", full, occupancy);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 10'(i)) begin
        n_fail++;
        $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h",
                 i, valid_out, data_out, 10'(i));
      end
    end
    cyc(1'b0, 1'b0, '0);
    n_checks++;
    if (empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 10'd0) begin
      n_fail++;
      $display("FAIL drain_end got e=%b v=%b d=%h want e=1 v=0 d=0",
               empty, valid_out, data_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(12'h100 + i));
    cyc(1'b1, 1'b0, 10'h3FF);
    n_checks++;
    if (occupancy !== 4'd8 || fifo_error !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow got o=%0d err=%b want o=8 err=1",
               occupancy, fifo_error);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_checks++;
      if (data_out !== 10'(12'h100 + i) || valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d got v=%b d=%h want v=1 d=%h",
                 i, valid_out, data_out, 10'(12'h100 + i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || fifo_error !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got e=%b err=%b want e=1 err=1",
               empty, fifo_error);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1'b0, 1'b1, '0);
    n_checks++;
    if (valid_out !== 1'b0 || fifo_error !== 1'b1 || occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL underflow got v=%b err=%b o=%0d want v=0 err=1 o=0",
               valid_out, fifo_error, occupancy);
    end
    do_reset();
    cyc(1'b1, 1'b1, 10'h155);
    n_checks++;
    if (occupancy !== 4'd1 || valid_out !== 1'b0 || fifo_error !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_pushpop got o=%0d v=%b err=%b want o=1 v=0 err=1",
               occupancy, valid_out, fifo_error);
    end
    cyc(1'b0, 1'b1, '0);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 10'h155) begin
      n_fail++;
      $display("FAIL empty_pushpop_word got v=%b d=%h want v=1 d=155",
               valid_out, data_out);
    end
  endtask

  task automatic test_full_pushpop_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(8'h10 + i));
    cyc(1'b1, 1'b1, 10'h018);
    n_checks++;
    if (data_out !== 10'h010 || valid_out !== 1'b1 || occupancy !== 4'd8
        || fifo_error !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop got d=%h v=%b o=%0d err=%b want 010 1 8 0",
               data_out, valid_out, occupancy, fifo_error);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_checks++;
      if (data_out !== 10'(8'h10 + i) || valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_%0d got v=%b d=%h want v=1 d=%h",
                 i, valid_out, data_out, 10'(8'h10 + i));
      end
    end
  endtask

  task automatic test_thresholds();
    afull_thr = 4'd6;
    aempty_thr = 4'd2;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b0, 10'($urandom));
      n_checks++;
      if (almost_full !== (k >= 6) || almost_empty !== (k <= 2)) begin
        n_fail++;
        $display("FAIL thr_push_%0d got af=%b ae=%b want af=%b ae=%b",
                 k, almost_full, almost_empty, k >= 6, k <= 2);
      end
    end
    @(negedge clk);
    push = 1'b1;
    data_in = 10'h2AA;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || empty !== 1'b1 || valid_out !== 1'b0
        || data_out !== 10'd0 || fifo_error !== 1'b0
        || almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got o=%0d e=%b v=%b d=%h err=%b af=%b ae=%b",
               occupancy, empty, valid_out, data_out, fifo_error,
               almost_full, almost_empty);
    end
    @(negedge clk);
    push = 1'b0;
    model_clear();
    reset = 1'b1;
    afull_thr = 4'd7;
    aempty_thr = 4'd1;
  endtask

  task automatic test_random();
    logic pu;
    logic po;
    int sz;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      afull_thr = 4'($urandom_range(0, 15));
      aempty_thr = 4'($urandom_range(0, 15));
      for (int c = 0; c < 120; c++) begin
        pu = ($urandom_range(0, 99) < (r == 1 ? 80 : 55));
        po = ($urandom_range(0, 99) < (r == 2 ? 80 : 45));
        if (c % 40 == 39) begin
          afull_thr = 4'($urandom_range(0, 15));
          aempty_thr = 4'($urandom_range(0, 15));
        end
        cyc(pu, po, 10'($urandom));
        sz = q.size();
        n_checks++;
        if (valid_out !== m_valid || data_out !== m_data
            || occupancy !== 4'(sz) || fifo_error !== m_err
            || full !== (sz == 8) || empty !== (sz == 0)
            || almost_full !== (sz >= int'(afull_thr))
            || almost_empty !== (sz <= int'(aempty_thr))) begin
          n_fail++;
          $display("FAIL rand_%0d_%0d got v=%b d=%h o=%0d err=%b f=%b e=%b af=%b ae=%b want v=%b d=%h o=%0d err=%b",
                   r, c, valid_out, data_out, occupancy, fifo_error, full,
                   empty, almost_full, almost_empty, m_valid, m_data, sz,
                   m_err);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_pushpop_wrap();
    test_thresholds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
